// File: rtl/times_table_engine_if.sv
// times_table_engine_if: lookup/rebuild bundle between a requester and the times-table engine
// master: drives rebuild, read, a, b; receives result, valid, ready, busy, rd_err
// slave : the engine side of the same signals
interface times_table_engine_if #(
    parameter int W  = 3,
    parameter int RW = 2 * W
);
    logic          rebuild;
    logic          read;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] result;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          rd_err;
    modport master (output rebuild, read, a, b, input result, valid, ready, busy, rd_err);
    modport slave  (input rebuild, read, a, b, output result, valid, ready, busy, rd_err);
endinterface

// File: rtl/times_table_engine.sv
// times_table_engine: self-filling a*b lookup RAM served through a read/valid handshake
// clk, rst_n (async, active low); tt.rebuild/read/a/b in; tt.result/valid/ready/busy/rd_err out
module times_table_engine #(
    parameter int W  = 3,
    parameter int RW = 2 * W
) (
    input logic                  clk,
    input logic                  rst_n,
    times_table_engine_if.slave  tt
);
    localparam int DEPTH = 1 << (2 * W);
    if (RW < 2 * W) begin : g_bad_rw
        $error("times_table_engine: RW must be at least 2*W");
    end
    typedef enum logic {FILL, READY} state_t;
    state_t state, state_nx;
    logic [2*W-1:0] cnt, sum;
    logic [2*W-1:0] mem [DEPTH];
    logic rdy, accept;
    assign rdy      = state == READY;
    assign accept   = rdy & tt.read;
    assign tt.ready = rdy;
    assign tt.busy  = ~rdy;
    always_comb begin
        state_nx = state;
        if (state == FILL && &cnt)
            state_nx = READY;
        else if (state == READY && tt.rebuild)
            state_nx = FILL;
    end
    // cnt = {ai, bi}; sum holds ai*bi and restarts whenever bi wraps.
    // Both sit at 0 in READY so a rebuild starts a clean fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            sum       <= '0;
            tt.result <= '0;
            tt.valid  <= 1'b0;
            tt.rd_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= state == FILL ? cnt + 1'b1 : '0;
            sum       <= state == FILL && !(&cnt[W-1:0]) ? sum + (2*W)'(cnt[2*W-1:W]) : '0;
            tt.result <= accept ? RW'(mem[{tt.a, tt.b}]) : tt.result;
            tt.valid  <= accept;
            tt.rd_err <= tt.read & ~rdy;
        end
    end
    always_ff @(posedge clk)
        if (state == FILL)
            mem[cnt] <= sum;
endmodule

// File: tb/tb_times_table_engine.sv
// tb_times_table_engine: directed vector bench for times_table_engine (W=3 and W=4/RW=10 instances)
module tb_times_table_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    times_table_engine_if #(.W(3), .RW(6))  i3();
    times_table_engine_if #(.W(4), .RW(10)) i4();
    times_table_engine #(.W(3), .RW(6))  u3 (.clk(clk), .rst_n(rst_n), .tt(i3));
    times_table_engine #(.W(4), .RW(10)) u4 (.clk(clk), .rst_n(rst_n), .tt(i4));
    int total = 0;
    int bad = 0;
    typedef struct {int a; int b; int res;} vec_t;
    vec_t v [6];
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic wait_rdy(input bit w4, output int n);
        n = 0;
        while (!(w4 ? i4.ready : i3.ready) && n < 1000) begin
            tick;
            n++;
        end
    endtask
    int n;
    initial begin
        v[0] = '{3, 5, 15};
        v[1] = '{1, 7, 7};
        v[2] = '{4, 4, 16};
        v[3] = '{7, 7, 49};
        v[4] = '{5, 3, 15};
        v[5] = '{0, 6, 0};
        rst_n = 1'b0;
        i3.rebuild = 1'b0; i3.read = 1'b0; i3.a = '0; i3.b = '0;
        i4.rebuild = 1'b0; i4.read = 1'b0; i4.a = '0; i4.b = '0;
        tick;
        tick;
        chk("rst_busy", i3.busy, 1);
        chk("rst_ready", i3.ready, 0);
        chk("rst_valid", i3.valid, 0);
        chk("rst_rd_err", i3.rd_err, 0);
        chk("rst_result", i3.result, 0);
        rst_n = 1'b1;
        wait_rdy(1'b0, n);
        chk("fill_len", n, 64);
        chk("busy_drop", i3.busy, 0);
        for (int i = 0; i < 6; i++) begin
            i3.read = 1'b1;
            i3.a = 3'(v[i].a);
            i3.b = 3'(v[i].b);
            tick;
            chk("b2b_valid", i3.valid, 1);
            chk("b2b_result", i3.result, v[i].res);
        end
        i3.read = 1'b0;
        tick;
        chk("hold_valid", i3.valid, 0);
        chk("hold_result", i3.result, 0);
        i3.rebuild = 1'b1; i3.read = 1'b1; i3.a = 3'd6; i3.b = 3'd4;
        tick;
        chk("rb_valid", i3.valid, 1);
        chk("rb_result", i3.result, 24);
        chk("rb_ready", i3.ready, 0);
        chk("rb_busy", i3.busy, 1);
        i3.rebuild = 1'b0; i3.read = 1'b0;
        repeat (3) tick;
        i3.read = 1'b1; i3.a = 3'd2; i3.b = 3'd2;
        tick;
        chk("err_pulse", i3.rd_err, 1);
        chk("err_valid", i3.valid, 0);
        chk("err_result", i3.result, 24);
        i3.read = 1'b0;
        i3.rebuild = 1'b1;
        tick;
        chk("err_once", i3.rd_err, 0);
        i3.rebuild = 1'b0;
        wait_rdy(1'b0, n);
        chk("refill_len", n + 5, 64);
        i3.read = 1'b1; i3.a = 3'd2; i3.b = 3'd2;
        tick;
        chk("late_valid", i3.valid, 1);
        chk("late_result", i3.result, 4);
        i3.read = 1'b0;
        i3.rebuild = 1'b1;
        tick;
        i3.rebuild = 1'b0;
        repeat (29) tick;
        i3.read = 1'b1;
        tick;
        chk("pre_rst_err", i3.rd_err, 1);
        i3.read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", i3.busy, 1);
        chk("mid_rst_ready", i3.ready, 0);
        chk("mid_rst_rd_err", i3.rd_err, 0);
        chk("mid_rst_result", i3.result, 0);
        chk("mid_rst_valid", i3.valid, 0);
        tick;
        rst_n = 1'b1;
        wait_rdy(1'b0, n);
        chk("rst_fill_len", n, 64);
        wait_rdy(1'b1, n);
        chk("w4_ready", i4.ready, 1);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                i4.read = 1'b1;
                i4.a = 4'(a);
                i4.b = 4'(b);
                tick;
                chk("sweep", {21'b0, i4.valid, i4.result}, 1024 + a * b);
            end
        end
        i4.read = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
